// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: state encoding,
// brick count, default score width and a brick-count helper.
package game_pkg;

  localparam int unsigned NUM_BRICKS  = 3;
  localparam int unsigned SCORE_W_DEF = 8;
  localparam int unsigned STATE_W     = 3;
  localparam int unsigned BRICK_CNT_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_LOST  = 3'd4,
    ST_OVER  = 3'd5,
    ST_WIN   = 3'd6
  } state_e;

  // Number of set bits in a brick mask.
  function automatic logic [BRICK_CNT_W-1:0] brick_count(input logic [NUM_BRICKS-1:0] v);
    logic [BRICK_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(NUM_BRICKS); i++) begin
      c = c + BRICK_CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-flop synchronizer followed by a registered
// rising-edge detector. A raw edge shows up as a one-cycle pulse three
// cycles later.
//   clk     : pixel clock
//   reset   : synchronous, active-low
//   i_btn   : raw asynchronous button level
//   o_pulse : one-cycle pulse on each synchronized rising edge
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_s1, r_s2, r_s3, r_pulse;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_pulse <= r_s2 & ~r_s3;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller for the brick/paddle playfield engine. Sequences
// attract, serve, play, pause, ball-lost, game-over and win, and keeps
// lives, score and the brick-alive mask.
//   clk, reset (sync, active-low), frame_tick (per-frame pulse)
//   btn_start, btn_pause : raw asynchronous buttons
//   ball_lost            : playfield terminal state level
//   brick_hit[2:0]       : per-brick collision pulses
//   play_rst_n, play_run, overlay_en : playfield / overlay controls
//   brick_alive, lives, score, seq_state : game status (all registered)
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned LOST_FRAMES  = 90,
  parameter int unsigned BRICK_POINTS = 10,
  parameter int unsigned SCORE_W      = SCORE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  btn_start,
  input  logic                  btn_pause,
  input  logic                  ball_lost,
  input  logic [NUM_BRICKS-1:0] brick_hit,
  output logic                  play_rst_n,
  output logic                  play_run,
  output logic                  overlay_en,
  output logic [NUM_BRICKS-1:0] brick_alive,
  output logic [1:0]            lives,
  output logic [SCORE_W-1:0]    score,
  output logic [STATE_W-1:0]    seq_state
);

  localparam int unsigned CNT_MAX = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic w_start_p, w_pause_p;

  state_e                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [1:0]            r_lives, w_lives_nxt;
  logic [SCORE_W-1:0]    r_score, w_score_nxt;
  logic [NUM_BRICKS-1:0] r_alive, w_alive_nxt, w_new_clr;
  logic [31:0]           w_sum;
  logic                  r_play_rst_n, w_play_rst_n;
  logic                  r_play_run, w_play_run;
  logic                  r_overlay_en, w_overlay_en;

  btn_sync_edge u_start (.clk(clk), .reset(reset), .i_btn(btn_start), .o_pulse(w_start_p));
  btn_sync_edge u_pause (.clk(clk), .reset(reset), .i_btn(btn_pause), .o_pulse(w_pause_p));

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_lives      <= 2'(LIVES_INIT);
      r_score      <= '0;
      r_alive      <= '1;
      r_play_rst_n <= 1'b0;
      r_play_run   <= 1'b0;
      r_overlay_en <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_lives      <= w_lives_nxt;
      r_score      <= w_score_nxt;
      r_alive      <= w_alive_nxt;
      r_play_rst_n <= w_play_rst_n;
      r_play_run   <= w_play_run;
      r_overlay_en <= w_overlay_en;
    end
  end

  // Next-state, datapath update and next-output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_lives_nxt  = r_lives;
    w_score_nxt  = r_score;
    w_alive_nxt  = r_alive;
    w_new_clr    = '0;
    w_sum        = '0;
    w_play_rst_n = 1'b1;
    w_play_run   = 1'b0;
    w_overlay_en = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_p) begin
          w_state_nxt = ST_SERVE;
          w_lives_nxt = 2'(LIVES_INIT);
          w_score_nxt = '0;
          w_alive_nxt = '1;
          w_cnt_nxt   = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (r_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            w_state_nxt = ST_PLAY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        // Hits are scored even when the state leaves PLAY this cycle.
        w_new_clr   = brick_hit & r_alive;
        w_alive_nxt = r_alive & ~brick_hit;
        w_sum       = 32'(r_score) + 32'(brick_count(w_new_clr)) * BRICK_POINTS;
        w_score_nxt = (w_sum > 32'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(w_sum);
        if (ball_lost) begin
          w_state_nxt = ST_LOST;
          w_cnt_nxt   = '0;
        end else if (r_alive == '0) begin
          w_state_nxt = ST_WIN;
        end else if (w_pause_p) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (w_pause_p || w_start_p) w_state_nxt = ST_PLAY;
      end
      ST_LOST: begin
        if (frame_tick) begin
          if (r_cnt == CNT_W'(LOST_FRAMES - 1)) begin
            w_lives_nxt = r_lives - 2'd1;
            w_state_nxt = (r_lives == 2'd1) ? ST_OVER : ST_SERVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_OVER, ST_WIN: begin
        if (w_start_p) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they land with it.
    case (w_state_nxt)
      ST_IDLE: begin
        w_play_rst_n = 1'b0;
        w_overlay_en = 1'b1;
      end
      ST_SERVE: w_play_rst_n = 1'b0;
      ST_PLAY:  w_play_run   = 1'b1;
      ST_OVER, ST_WIN: w_overlay_en = 1'b1;
      default: ;
    endcase
  end

  assign play_rst_n  = r_play_rst_n;
  assign play_run    = r_play_run;
  assign overlay_en  = r_overlay_en;
  assign brick_alive = r_alive;
  assign lives       = r_lives;
  assign score       = r_score;
  assign seq_state   = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer. Instance a uses SCORE_W=8/10 points,
// instance b uses SCORE_W=5/12 points so its score saturates at 31.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset, frame_tick, btn_start, btn_pause, ball_lost;
  logic [2:0] brick_hit;

  logic       a_rst_n, a_run, a_ovl, b_rst_n, b_run, b_ovl;
  logic [2:0] a_alive, a_state, b_alive, b_state;
  logic [1:0] a_lives, b_lives;
  logic [7:0] a_score;
  logic [4:0] b_score;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_sequencer #(.LIVES_INIT(3), .SERVE_FRAMES(4), .LOST_FRAMES(2),
                   .BRICK_POINTS(10), .SCORE_W(8)) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_start(btn_start),
    .btn_pause(btn_pause), .ball_lost(ball_lost), .brick_hit(brick_hit),
    .play_rst_n(a_rst_n), .play_run(a_run), .overlay_en(a_ovl),
    .brick_alive(a_alive), .lives(a_lives), .score(a_score), .seq_state(a_state));

  game_sequencer #(.LIVES_INIT(3), .SERVE_FRAMES(4), .LOST_FRAMES(2),
                   .BRICK_POINTS(12), .SCORE_W(5)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_start(btn_start),
    .btn_pause(btn_pause), .ball_lost(ball_lost), .brick_hit(brick_hit),
    .play_rst_n(b_rst_n), .play_run(b_run), .overlay_en(b_ovl),
    .brick_alive(b_alive), .lives(b_lives), .score(b_score), .seq_state(b_state));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    btn_start = 1'b1; step(4); btn_start = 1'b0; step(3);
  endtask

  task automatic press_pause();
    btn_pause = 1'b1; step(4); btn_pause = 1'b0; step(3);
  endtask

  task automatic tick();
    frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(1);
  endtask

  task automatic chk_state(input string tag, input logic [2:0] s);
    chk({tag, "_a"}, 32'(a_state), 32'(s));
    chk({tag, "_b"}, 32'(b_state), 32'(s));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_state({tag, "_state"}, 3'd0);
    chk({tag, "_rst_n"}, 32'(a_rst_n), 32'd0);
    chk({tag, "_run"},   32'(a_run),   32'd0);
    chk({tag, "_ovl"},   32'(a_ovl),   32'd1);
    chk({tag, "_alive"}, 32'(a_alive), 32'd7);
    chk({tag, "_lives"}, 32'(a_lives), 32'd3);
    chk({tag, "_score"}, 32'(a_score), 32'd0);
    chk({tag, "_score_b"}, 32'(b_score), 32'd0);
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
    ball_lost = 1'b0; brick_hit = 3'b000;
    step(2);
    chk_reset_vals("reset");
    reset = 1'b1;
    step(1);

    // Game 1: serve, scoring, pause, simultaneous hit/lost, win via serve.
    press_start();
    chk_state("serve", 3'd1);
    chk("serve_ovl", 32'(a_ovl), 32'd0);
    chk("serve_rst_n", 32'(a_rst_n), 32'd0);
    chk("serve_lives", 32'(a_lives), 32'd3);
    repeat (3) tick();
    chk_state("serve_3ticks", 3'd1);
    chk("serve_3ticks_run", 32'(a_run), 32'd0);
    frame_tick = 1'b1;
    chk("run_before_4th", 32'(a_run), 32'd0);
    step(1);
    frame_tick = 1'b0;
    chk("run_after_4th", 32'(a_run), 32'd1);
    chk("play_rst_n", 32'(a_rst_n), 32'd1);
    chk_state("play", 3'd2);

    brick_hit = 3'b101; step(1); brick_hit = 3'b000;
    chk("hit101_score", 32'(a_score), 32'd20);
    chk("hit101_score_b", 32'(b_score), 32'd24);
    chk("hit101_alive", 32'(a_alive), 32'd2);
    brick_hit = 3'b001; step(1); brick_hit = 3'b000;
    chk("rehit_score", 32'(a_score), 32'd20);
    chk("rehit_alive", 32'(a_alive), 32'd2);

    press_start();
    chk_state("start_in_play", 3'd2);

    press_pause();
    chk_state("pause", 3'd3);
    chk("pause_run", 32'(a_run), 32'd0);
    chk("pause_rst_n", 32'(a_rst_n), 32'd1);
    brick_hit = 3'b010; step(1); brick_hit = 3'b000;
    chk("pause_hit_alive", 32'(a_alive), 32'd2);
    chk("pause_hit_score", 32'(a_score), 32'd20);
    tick(); tick();
    chk_state("pause_ticks", 3'd3);
    press_pause();
    chk_state("resume", 3'd2);
    chk("resume_run", 32'(a_run), 32'd1);

    brick_hit = 3'b010; ball_lost = 1'b1; step(1);
    brick_hit = 3'b000; ball_lost = 1'b0;
    chk("hitlost_score", 32'(a_score), 32'd30);
    chk("hitlost_score_sat_b", 32'(b_score), 32'd31);
    chk("hitlost_alive", 32'(a_alive), 32'd0);
    chk_state("hitlost", 3'd4);
    chk("lost_run", 32'(a_run), 32'd0);
    chk("lost_rst_n", 32'(a_rst_n), 32'd1);
    tick();
    chk_state("lost_1tick", 3'd4);
    chk("lost_1tick_lives", 32'(a_lives), 32'd3);
    tick();
    chk_state("lost_done", 3'd1);
    chk("lost_done_lives", 32'(a_lives), 32'd2);
    chk("lost_done_score_b", 32'(b_score), 32'd31);
    repeat (3) tick();
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    chk_state("replay", 3'd2);
    step(1);
    chk_state("win", 3'd6);
    chk("win_ovl", 32'(a_ovl), 32'd1);
    chk("win_run", 32'(a_run), 32'd0);
    chk("win_rst_n", 32'(a_rst_n), 32'd1);

    press_start();
    chk_state("idle_again", 3'd0);
    chk("idle_ovl", 32'(a_ovl), 32'd1);
    chk("idle_rst_n", 32'(a_rst_n), 32'd0);

    // Game 2: lose all lives.
    press_start();
    chk_state("g2_serve", 3'd1);
    chk("g2_lives", 32'(a_lives), 32'd3);
    chk("g2_score", 32'(a_score), 32'd0);
    chk("g2_alive", 32'(a_alive), 32'd7);
    for (int k = 0; k < 3; k++) begin
      repeat (4) tick();
      chk_state("g2_play", 3'd2);
      ball_lost = 1'b1; step(1); ball_lost = 1'b0;
      chk_state("g2_lost", 3'd4);
      tick(); tick();
      chk("g2_lives_dec", 32'(a_lives), 32'(2 - k));
      chk_state("g2_after_lost", (k == 2) ? 3'd5 : 3'd1);
    end
    chk("over_ovl", 32'(a_ovl), 32'd1);
    chk("over_run", 32'(a_run), 32'd0);
    chk("over_rst_n", 32'(a_rst_n), 32'd1);

    // Game 3: reset asserted mid-PLAY.
    press_start();
    press_start();
    repeat (4) tick();
    chk_state("g3_play", 3'd2);
    brick_hit = 3'b100; step(1); brick_hit = 3'b000;
    chk("g3_score", 32'(a_score), 32'd10);
    chk("g3_score_b", 32'(b_score), 32'd12);
    chk("g3_alive", 32'(a_alive), 32'd3);
    reset = 1'b0;
    step(1);
    chk_reset_vals("midreset");
    reset = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
